// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-byte I2C controller (START, addr+R/W, one data byte, ACK/NACK, STOP)
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       pclk,
    input  logic       preset_n,
    input  logic       start,
    input  logic [6:0] slave_addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, WRITE, WACK, READ, MNACK, STOP
    } state_t;

    state_t         state, state_nxt;
    logic [DW-1:0]  div_cnt;
    logic [1:0]     phase;
    logic [2:0]     bit_cnt;
    logic           rw_q;
    logic [7:0]     wdata_q;
    logic [7:0]     tx_shift;
    logic [7:0]     rx_shift;
    logic           ack_smp;

    logic stretch_hold, quarter_end, bit_end, sample, last_bit, accept;

    // Target may hold SCL low after we release it; freeze the divider until it lets go
    assign stretch_hold = (phase == 2'd2) && !scl_in;
    assign quarter_end  = (state != IDLE) && (div_cnt == DIV_LAST) && !stretch_hold;
    assign bit_end      = quarter_end && (phase == 2'd3);
    assign sample       = quarter_end && (phase == 2'd2);
    assign last_bit     = (bit_cnt == 3'd7);
    assign accept       = (state == IDLE) && start;
    assign busy         = (state != IDLE);

    // State register
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state and open-drain line drive; SCL low in Q0/Q1, SDA changes only at Q0
    always_comb begin
        state_nxt = state;
        scl_oe    = 1'b0;
        sda_oe    = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = START;
            START: begin
                sda_oe = phase[1];
                scl_oe = (phase == 2'd3);
                if (bit_end) state_nxt = ADDR;
            end
            ADDR: begin
                scl_oe = ~phase[1];
                sda_oe = ~tx_shift[7];
                if (bit_end && last_bit) state_nxt = AACK;
            end
            AACK: begin
                scl_oe = ~phase[1];
                if (bit_end) state_nxt = ack_smp ? STOP : (rw_q ? READ : WRITE);
            end
            WRITE: begin
                scl_oe = ~phase[1];
                sda_oe = ~tx_shift[7];
                if (bit_end && last_bit) state_nxt = WACK;
            end
            WACK: begin
                scl_oe = ~phase[1];
                if (bit_end) state_nxt = STOP;
            end
            READ: begin
                scl_oe = ~phase[1];
                if (bit_end && last_bit) state_nxt = MNACK;
            end
            MNACK: begin
                scl_oe = ~phase[1];
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                scl_oe = ~phase[1];
                sda_oe = (phase != 2'd3);
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit timing, request capture, shift registers and status flags
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            div_cnt  <= '0;
            phase    <= 2'd0;
            bit_cnt  <= 3'd0;
            rw_q     <= 1'b0;
            wdata_q  <= 8'h00;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            ack_smp  <= 1'b0;
            ack_err  <= 1'b0;
            rdata    <= 8'h00;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                div_cnt <= '0;
                phase   <= 2'd0;
            end else if (!stretch_hold) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    phase   <= phase + 2'd1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
            if (accept) begin
                rw_q     <= rw;
                wdata_q  <= wdata;
                tx_shift <= {slave_addr, rw};
                bit_cnt  <= 3'd0;
                ack_err  <= 1'b0;
            end
            if (sample) begin
                ack_smp <= sda_in;
                if (state == READ) rx_shift <= {rx_shift[6:0], sda_in};
            end
            if (bit_end) begin
                case (state)
                    ADDR, WRITE: begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        bit_cnt  <= bit_cnt + 3'd1;
                    end
                    READ: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) rdata <= rx_shift;
                    end
                    AACK: begin
                        if (ack_smp) ack_err  <= 1'b1;
                        else         tx_shift <= wdata_q;
                    end
                    WACK: if (ack_smp) ack_err <= 1'b1;
                    STOP: done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - directed bench for i2c_master_ctrl with a behavioural I2C target
module tb_i2c_master_ctrl;

    logic       pclk = 1'b0;
    logic       preset_n;
    logic       start;
    logic [6:0] slave_addr;
    logic       rw;
    logic [7:0] wdata;
    logic       scl_in, sda_in;
    logic       scl_oe, sda_oe, busy, done, ack_err;
    logic [7:0] rdata;

    logic tgt_scl_low = 1'b0;
    logic tgt_sda_low = 1'b0;

    assign scl_in = ~(scl_oe | tgt_scl_low);
    assign sda_in = ~(sda_oe | tgt_sda_low);

    always #5 pclk = ~pclk;

    i2c_master_ctrl #(.CLK_DIV(4)) dut (
        .pclk(pclk), .preset_n(preset_n), .start(start), .slave_addr(slave_addr),
        .rw(rw), .wdata(wdata), .scl_in(scl_in), .sda_in(sda_in),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .busy(busy), .done(done),
        .ack_err(ack_err), .rdata(rdata)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;

    // target configuration, set by the stimulus while the bus is idle
    logic       cfg_ack_addr = 1'b1;
    logic       cfg_ack_data = 1'b1;
    logic       cfg_stretch  = 1'b0;
    logic [7:0] cfg_rd_byte  = 8'h00;

    // target observations
    int         nrise = 0;
    int         start_seen = 0;
    int         stop_seen = 0;
    int         done_cnt = 0;
    int         stretch_cnt = 0;
    int         nxt;
    logic       stretch_arm = 1'b0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic [7:0] addr_cap = 8'h00, data_cap = 8'h00;
    logic       ack1_cap = 1'b1, ack2_cap = 1'b1;

    always @(posedge pclk) cyc <= cyc + 1;

    // Behavioural target: watches the wired bus on the falling pclk edge
    always @(negedge pclk) begin
        prev_scl <= scl_in;
        prev_sda <= sda_in;
        if (done) done_cnt <= done_cnt + 1;
        if (scl_in && prev_scl && prev_sda && !sda_in) begin
            start_seen  <= start_seen + 1;
            nrise       <= 0;
            tgt_sda_low <= 1'b0;
        end else if (scl_in && prev_scl && !prev_sda && sda_in) begin
            stop_seen <= stop_seen + 1;
        end
        if (!prev_scl && scl_in) begin
            nrise <= nrise + 1;
            if (nrise + 1 <= 8)       addr_cap <= {addr_cap[6:0], sda_in};
            else if (nrise + 1 == 9)  ack1_cap <= sda_in;
            else if (nrise + 1 <= 17) data_cap <= {data_cap[6:0], sda_in};
            else if (nrise + 1 == 18) ack2_cap <= sda_in;
        end
        if (prev_scl && !scl_in) begin
            nxt = nrise + 1;
            tgt_sda_low <= 1'b0;
            if (nxt == 9)
                tgt_sda_low <= cfg_ack_addr;
            else if (cfg_ack_addr && addr_cap[0] && nxt >= 10 && nxt <= 17)
                tgt_sda_low <= ~cfg_rd_byte[17 - nxt];
            else if (cfg_ack_addr && !addr_cap[0] && nxt == 18)
                tgt_sda_low <= cfg_ack_data;
            if (cfg_stretch && nxt == 13) begin
                tgt_scl_low <= 1'b1;
                stretch_arm <= 1'b1;
            end
        end
        if (stretch_cnt > 0) begin
            stretch_cnt <= stretch_cnt - 1;
            if (stretch_cnt == 1) tgt_scl_low <= 1'b0;
        end else if (stretch_arm && !scl_oe) begin
            stretch_cnt <= 40;
            stretch_arm <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then scramble the request inputs to prove capture
    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] d);
        @(negedge pclk);
        slave_addr = a; rw = r; wdata = d; start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        t0 = cyc;
        slave_addr = ~a; rw = ~r; wdata = ~d;
    endtask

    task automatic wait_done(output int lat);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge pclk);
            n++;
        end
        lat = done ? (cyc - t0) : -1;
    endtask

    int lat, s0, p0, dc0;

    initial begin
        preset_n = 1'b1; start = 1'b0; slave_addr = 7'h00; rw = 1'b0; wdata = 8'h00;
        #1 preset_n = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_scl_oe", 32'(scl_oe), 32'h0);
        check("rst_sda_oe", 32'(sda_oe), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ack_err", 32'(ack_err), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h00);
        preset_n = 1'b1;
        repeat (50) @(negedge pclk);
        check("idle_lines", 32'({scl_oe, sda_oe, busy}), 32'h0);
        check("idle_no_done", 32'(done_cnt), 32'h0);

        // write 0x2A / 0xA5, target ACKs both bytes
        s0 = start_seen; p0 = stop_seen;
        issue(7'h2A, 1'b0, 8'hA5);
        check("wr_busy", 32'(busy), 32'h1);
        wait_done(lat);
        check("wr_latency", 32'(lat), 32'd320);
        check("wr_addr_byte", 32'(addr_cap), 32'h54);
        check("wr_data_byte", 32'(data_cap), 32'hA5);
        check("wr_ack_bits", 32'({ack1_cap, ack2_cap}), 32'h0);
        check("wr_ack_err", 32'(ack_err), 32'h0);
        check("wr_start_cond", 32'(start_seen - s0), 32'd1);
        check("wr_stop_cond", 32'(stop_seen - p0), 32'd1);
        check("wr_rises", 32'(nrise), 32'd19);
        check("wr_busy_at_done", 32'(busy), 32'h0);
        @(negedge pclk);
        check("wr_done_pulse", 32'(done), 32'h0);

        // read from 0x51, target returns 0x3C, controller NACKs
        cfg_rd_byte = 8'h3C;
        issue(7'h51, 1'b1, 8'h00);
        wait_done(lat);
        check("rd_latency", 32'(lat), 32'd320);
        check("rd_addr_byte", 32'(addr_cap), 32'hA3);
        check("rd_master_nack", 32'(ack2_cap), 32'h1);
        check("rd_rdata", 32'(rdata), 32'h3C);
        check("rd_ack_err", 32'(ack_err), 32'h0);

        // address NACK: no target response
        cfg_ack_addr = 1'b0;
        p0 = stop_seen;
        issue(7'h10, 1'b0, 8'h77);
        wait_done(lat);
        check("nack_latency", 32'(lat), 32'd176);
        check("nack_ack_err", 32'(ack_err), 32'h1);
        check("nack_addr_byte", 32'(addr_cap), 32'h20);
        check("nack_rises", 32'(nrise), 32'd10);
        check("nack_stop_cond", 32'(stop_seen - p0), 32'd1);
        repeat (10) @(negedge pclk);
        check("nack_err_held", 32'(ack_err), 32'h1);
        cfg_ack_addr = 1'b1;

        // clock stretching of 40 cycles during data bit 3
        cfg_stretch = 1'b1;
        issue(7'h45, 1'b0, 8'hC3);
        check("st_err_cleared", 32'(ack_err), 32'h0);
        wait_done(lat);
        cfg_stretch = 1'b0;
        check("st_latency", 32'(lat), 32'd360);
        check("st_addr_byte", 32'(addr_cap), 32'h8A);
        check("st_data_byte", 32'(data_cap), 32'hC3);
        check("st_ack_err", 32'(ack_err), 32'h0);
        check("st_rdata_held", 32'(rdata), 32'h3C);

        // reset in the middle of data bit 4
        issue(7'h33, 1'b0, 8'h5A);
        repeat (230) @(negedge pclk);
        check("mid_scl_low", 32'(scl_oe), 32'h1);
        preset_n = 1'b0;
        #1;
        check("mid_rst_lines", 32'({scl_oe, sda_oe}), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        repeat (4) @(negedge pclk);
        check("mid_rst_rdata", 32'(rdata), 32'h00);
        preset_n = 1'b1;
        repeat (5) @(negedge pclk);

        // fresh transfer after reset, with a start pulse while busy that must be ignored
        dc0 = done_cnt;
        issue(7'h33, 1'b0, 8'h5A);
        repeat (100) @(negedge pclk);
        slave_addr = 7'h7F; wdata = 8'hFF; rw = 1'b1; start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        wait_done(lat);
        check("re_latency", 32'(lat), 32'd320);
        check("re_addr_byte", 32'(addr_cap), 32'h66);
        check("re_data_byte", 32'(data_cap), 32'h5A);
        repeat (400) @(negedge pclk);
        check("re_single_done", 32'(done_cnt - dc0), 32'd1);
        check("re_idle", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule
